multicycle_cu: RTL

- Parametrised multi-cycle control unit for the RV32I core; successor to the single-cycle combinational decoder.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB.
- Handshakes with the unified memory port and drives datapath enables, ALU control and immediate format.
- Counts retired instructions and flags memory time-outs.

---
 rtl/cu_pkg.sv | 67 ++++++
 rtl/alu_decoder.sv | 40 ++++
 rtl/multicycle_cu.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: FSM states,
// opcode constants, ALU / immediate / result-source encodings and small
// decode helpers used by both the top and the ALU decoder.
package cu_pkg;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4,
    FAULT   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;
  localparam logic [1:0] RES_IMM = 2'd3;

  function automatic logic opcode_known(input logic [6:0] op);
    return (op == OPC_LOAD) || (op == OPC_STORE) || (op == OPC_OP) ||
           (op == OPC_OP_IMM) || (op == OPC_BRANCH) || (op == OPC_JAL) ||
           (op == OPC_LUI);
  endfunction

  // Only register-register ops constrain funct7; everything else is free.
  function automatic logic funct7_legal(input logic [6:0] op, input logic [6:0] f7);
    return (op != OPC_OP) || (f7 == 7'b0000000) || (f7 == 7'b0100000);
  endfunction

  // Immediate format selected by opcode; anything without a special format uses I.
  function automatic logic [2:0] imm_fmt_of(input logic [6:0] op);
    logic [2:0] fmt;
    fmt = IMM_I;
    if (op == OPC_STORE)       fmt = IMM_S;
    else if (op == OPC_BRANCH) fmt = IMM_B;
    else if (op == OPC_LUI)    fmt = IMM_U;
    else if (op == OPC_JAL)    fmt = IMM_J;
    return fmt;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational map from opcode/funct3/funct7 to the ALU operation code.
module alu_decoder
  import cu_pkg::*;
#(
  parameter int ALU_CTRL_W = 4
) (
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  output logic [ALU_CTRL_W-1:0] alu_ctrl
);

  logic [3:0] op_sel;

  // Select the ALU operation; address calculation and jumps fall back to ADD.
  always_comb begin
    op_sel = ALU_ADD;
    if (opcode == OPC_OP || opcode == OPC_OP_IMM) begin
      case (funct3)
        3'b000:  op_sel = (opcode == OPC_OP && funct7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
        3'b001:  op_sel = ALU_SLL;
        3'b010:  op_sel = ALU_SLT;
        3'b011:  op_sel = ALU_SLTU;
        3'b100:  op_sel = ALU_XOR;
        3'b101:  op_sel = funct7[5] ? ALU_SRA : ALU_SRL;
        3'b110:  op_sel = ALU_OR;
        default: op_sel = ALU_AND;
      endcase
    end else if (opcode == OPC_BRANCH) begin
      case (funct3[2:1])
        2'b10:   op_sel = ALU_SLT;
        2'b11:   op_sel = ALU_SLTU;
        default: op_sel = ALU_SUB;
      endcase
    end
  end

  assign alu_ctrl = ALU_CTRL_W'(op_sel);

endmodule

// File: rtl/multicycle_cu.sv
// Multi-cycle RV32I control unit: sequences FETCH/DECODE/EXECUTE/MEM/WB,
// handshakes with the unified memory port, counts retired instructions and
// traps memory time-outs into a sticky FAULT state.
// Optional build macro CU_ILLEGAL_TRAP_EN: illegal encodings enter FAULT and
// raise the extra sticky output illegal_o instead of being skipped as NOPs.
//
// state   | meaning
// FETCH   | request instruction at PC, latch IR and PC+4 on ready
// DECODE  | one cycle, immediate format becomes valid
// EXECUTE | ALU operation, branch/jump PC update
// MEM     | load/store data access at ALU address
// WB      | register-file write, instruction retires
// FAULT   | memory time-out (or illegal op), left only by reset
module multicycle_cu
  import cu_pkg::*;
#(
  parameter int ALU_CTRL_W  = 4,
  parameter int IMM_FMT_W   = 3,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            opcode_i,
  input  logic [2:0]            funct3_i,
  input  logic [6:0]            funct7_i,
  input  logic                  mem_ready_i,
  input  logic                  branch_taken_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic                  addr_src_o,
  output logic                  ir_we_o,
  output logic                  pc_we_o,
  output logic                  jump_o,
  output logic                  reg_we_o,
  output logic [1:0]            result_src_o,
  output logic                  alu_src_b_o,
  output logic [ALU_CTRL_W-1:0] alu_ctrl_o,
  output logic [IMM_FMT_W-1:0]  imm_fmt_o,
  output logic [CNT_W-1:0]      instret_o,
  output logic                  fault_o
`ifdef CU_ILLEGAL_TRAP_EN
  ,
  output logic                  illegal_o
`endif
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t                  state_q, state_d;
  logic [WAIT_W-1:0]       wait_q;
  logic [CNT_W-1:0]        instret_q;
  logic [ALU_CTRL_W-1:0]   dec_alu;
  logic                    mem_phase;
  logic                    timeout;
  logic                    decode_ok;
  logic                    retire;

  alu_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_decoder (
    .opcode   (opcode_i),
    .funct3   (funct3_i),
    .funct7   (funct7_i),
    .alu_ctrl (dec_alu)
  );

  assign mem_phase = (state_q == FETCH) || (state_q == MEM);
  // Fires on the MEM_TIMEOUT-th consecutive cycle without mem_ready_i.
  assign timeout   = mem_phase && !mem_ready_i && (wait_q == WAIT_LAST);
  assign decode_ok = opcode_known(opcode_i) && funct7_legal(opcode_i, funct7_i);

  // State register; reset wins over any pending memory request.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Next-state selection and retire detection.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      FETCH: begin
        if (timeout)          state_d = FAULT;
        else if (mem_ready_i) state_d = DECODE;
      end
      DECODE: begin
        if (decode_ok) state_d = EXECUTE;
`ifdef CU_ILLEGAL_TRAP_EN
        else           state_d = FAULT;
`else
        else           state_d = FETCH;
`endif
      end
      EXECUTE: begin
        if (opcode_i == OPC_LOAD || opcode_i == OPC_STORE) begin
          state_d = MEM;
        end else if (opcode_i == OPC_BRANCH) begin
          state_d = FETCH;
          retire  = 1'b1;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        if (timeout) begin
          state_d = FAULT;
        end else if (mem_ready_i) begin
          if (opcode_i == OPC_STORE) begin
            state_d = FETCH;
            retire  = 1'b1;
          end else begin
            state_d = WB;
          end
        end
      end
      WB: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      FAULT:   state_d = FAULT;
      default: state_d = FETCH;
    endcase
  end

  // Outputs decoded from state and IR fields, forced low while reset is held.
  always_comb begin
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    addr_src_o   = 1'b0;
    ir_we_o      = 1'b0;
    pc_we_o      = 1'b0;
    jump_o       = 1'b0;
    reg_we_o     = 1'b0;
    result_src_o = RES_ALU;
    alu_src_b_o  = 1'b0;
    alu_ctrl_o   = '0;
    imm_fmt_o    = '0;
    fault_o      = 1'b0;
    if (rst_n) begin
      if (state_q == DECODE || state_q == EXECUTE || state_q == MEM || state_q == WB)
        imm_fmt_o = IMM_FMT_W'(imm_fmt_of(opcode_i));
      case (state_q)
        FETCH: begin
          mem_req_o = 1'b1;
          ir_we_o   = mem_ready_i;
          pc_we_o   = mem_ready_i;
        end
        EXECUTE: begin
          alu_ctrl_o  = dec_alu;
          alu_src_b_o = (opcode_i == OPC_OP_IMM) || (opcode_i == OPC_LOAD) ||
                        (opcode_i == OPC_STORE);
          if (opcode_i == OPC_BRANCH) begin
            pc_we_o = branch_taken_i;
            jump_o  = branch_taken_i;
          end else if (opcode_i == OPC_JAL) begin
            pc_we_o = 1'b1;
            jump_o  = 1'b1;
          end
        end
        MEM: begin
          mem_req_o  = 1'b1;
          addr_src_o = 1'b1;
          mem_we_o   = (opcode_i == OPC_STORE);
        end
        WB: begin
          reg_we_o = 1'b1;
          if (opcode_i == OPC_LOAD)     result_src_o = RES_MEM;
          else if (opcode_i == OPC_JAL) result_src_o = RES_PC4;
          else if (opcode_i == OPC_LUI) result_src_o = RES_IMM;
        end
        FAULT:   fault_o = 1'b1;
        default: ;
      endcase
    end
  end

  // Memory wait counter: runs while a request is stalled, clears otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n)                        wait_q <= '0;
    else if (mem_phase && !mem_ready_i) wait_q <= wait_q + 1'b1;
    else                               wait_q <= '0;
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!rst_n)      instret_q <= '0;
    else if (retire) instret_q <= instret_q + 1'b1;
  end

  assign instret_o = instret_q;

`ifdef CU_ILLEGAL_TRAP_EN
  logic illegal_q;

  // Sticky illegal-instruction flag, set together with the FAULT entry.
  always_ff @(posedge clk) begin
    if (!rst_n)                                illegal_q <= 1'b0;
    else if (state_q == DECODE && !decode_ok) illegal_q <= 1'b1;
  end

  assign illegal_o = illegal_q;
`endif

endmodule
